// File: rtl/vga_pkg.sv
// Shared VGA drawing definitions: screen geometry, colour constants,
// scheduler state encoding and a small index-width helper.
package vga_pkg;

   localparam int unsigned SCREEN_W = 320;
   localparam int unsigned SCREEN_H = 240;
   localparam int unsigned COLOUR_W = 3;
   localparam int unsigned X_W      = 9;
   localparam int unsigned Y_W      = 8;

   localparam logic [COLOUR_W-1:0] COL_BLACK  = 3'b000;
   localparam logic [COLOUR_W-1:0] COL_YELLOW = 3'b110;
   localparam logic [COLOUR_W-1:0] COL_WHITE  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Bits needed to encode a requester index (at least one).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req   - request vector
//   i_last  - index of the previous winner; search starts one above it
//   o_grant - one-hot grant (all zero when no request)
//   o_idx   - encoded index of the granted requester
module rr_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx
);

   logic        w_found;
   int unsigned w_pos;

   // Walk last+1 .. last+NUM_REQ (mod NUM_REQ); first set request wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_pos = (32'(i_last) + k) % NUM_REQ;
         if (!w_found && i_req[IDX_W'(w_pos)]) begin
            w_found                = 1'b1;
            o_grant[IDX_W'(w_pos)] = 1'b1;
            o_idx                  = IDX_W'(w_pos);
         end
      end
   end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Round-robin scheduler that fills client rectangles onto the VGA adapter
// pixel port, one pixel per clock, with off-screen pixels suppressed.
// Ports:
//   iClock, iReset          - clock, synchronous active-high reset
//   iReq                    - per-client request level
//   iX/iY/iW/iH/iColour     - packed per-client rectangle fields
//   oAck                    - one-hot grant pulse (GRANT cycle)
//   oBusy                   - high whenever not IDLE
//   oDone                   - one-cycle pulse when a rectangle completes
//   oX/oY/oColour/oPlot     - registered pixel write to the VGA adapter
module vga_draw_scheduler
   import vga_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DIM_W   = 5
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic [NUM_REQ-1:0]            iReq,
   input  logic [X_W*NUM_REQ-1:0]        iX,
   input  logic [Y_W*NUM_REQ-1:0]        iY,
   input  logic [DIM_W*NUM_REQ-1:0]      iW,
   input  logic [DIM_W*NUM_REQ-1:0]      iH,
   input  logic [COLOUR_W*NUM_REQ-1:0]   iColour,
   output logic [NUM_REQ-1:0]            oAck,
   output logic                          oBusy,
   output logic                          oDone,
   output logic [X_W-1:0]                oX,
   output logic [Y_W-1:0]                oY,
   output logic [COLOUR_W-1:0]           oColour,
   output logic                          oPlot
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);
   localparam int unsigned SX_W  = X_W + 1;
   localparam int unsigned SY_W  = Y_W + 1;

   state_t               r_state, w_state_n;
   logic [IDX_W-1:0]     r_win, w_win_n;
   logic [IDX_W-1:0]     r_last, w_last_n;
   logic [X_W-1:0]       r_x0, w_x0_n;
   logic [Y_W-1:0]       r_y0, w_y0_n;
   logic [DIM_W-1:0]     r_w, w_w_n;
   logic [DIM_W-1:0]     r_h, w_h_n;
   logic [COLOUR_W-1:0]  r_colour, w_colour_n;
   logic [DIM_W-1:0]     r_col, w_col_n;
   logic [DIM_W-1:0]     r_row, w_row_n;

   logic [NUM_REQ-1:0]   r_ack, w_ack_n;
   logic                 r_busy, r_done, w_done_n;
   logic [X_W-1:0]       r_px;
   logic [Y_W-1:0]       r_py;
   logic [COLOUR_W-1:0]  r_pcolour;
   logic                 r_plot, w_plot_n;
   logic                 w_emit;
   logic [SX_W-1:0]      w_xs;
   logic [SY_W-1:0]      w_ys;

   logic [NUM_REQ-1:0]   w_arb_grant;
   logic [IDX_W-1:0]     w_arb_idx;
   logic [X_W-1:0]       w_sel_x;
   logic [Y_W-1:0]       w_sel_y;
   logic [DIM_W-1:0]     w_sel_w;
   logic [DIM_W-1:0]     w_sel_h;
   logic [COLOUR_W-1:0]  w_sel_colour;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (iReq),
      .i_last  (r_last),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx)
   );

   // Field mux for the current winner; only consumed in GRANT.
   always_comb begin
      w_sel_x      = '0;
      w_sel_y      = '0;
      w_sel_w      = '0;
      w_sel_h      = '0;
      w_sel_colour = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_win == IDX_W'(i)) begin
            w_sel_x      = iX[i*X_W +: X_W];
            w_sel_y      = iY[i*Y_W +: Y_W];
            w_sel_w      = iW[i*DIM_W +: DIM_W];
            w_sel_h      = iH[i*DIM_W +: DIM_W];
            w_sel_colour = iColour[i*COLOUR_W +: COLOUR_W];
         end
      end
   end

   // Next state, counters and the pixel to register this cycle.
   // The counters always hold the coordinate of the pixel being presented,
   // so the GRANT cycle already emits pixel (0,0) from the live fields.
   always_comb begin
      w_state_n  = r_state;
      w_ack_n    = '0;
      w_done_n   = 1'b0;
      w_emit     = 1'b0;
      w_win_n    = r_win;
      w_last_n   = r_last;
      w_x0_n     = r_x0;
      w_y0_n     = r_y0;
      w_w_n      = r_w;
      w_h_n      = r_h;
      w_colour_n = r_colour;
      w_col_n    = r_col;
      w_row_n    = r_row;

      case (r_state)
         ST_IDLE: begin
            if (|iReq) begin
               w_state_n = ST_GRANT;
               w_ack_n   = w_arb_grant;
               w_win_n   = w_arb_idx;
            end
         end
         ST_GRANT: begin
            w_last_n   = r_win;
            w_x0_n     = w_sel_x;
            w_y0_n     = w_sel_y;
            w_w_n      = w_sel_w;
            w_h_n      = w_sel_h;
            w_colour_n = w_sel_colour;
            w_col_n    = '0;
            w_row_n    = '0;
            if (w_sel_w == '0 || w_sel_h == '0) begin
               w_state_n = ST_DONE;
               w_done_n  = 1'b1;
            end else begin
               w_state_n = ST_DRAW;
               w_emit    = 1'b1;
            end
         end
         ST_DRAW: begin
            if (r_col == r_w - DIM_W'(1)) begin
               if (r_row == r_h - DIM_W'(1)) begin
                  w_state_n = ST_DONE;
                  w_done_n  = 1'b1;
               end else begin
                  w_col_n = '0;
                  w_row_n = r_row + DIM_W'(1);
                  w_emit  = 1'b1;
               end
            end else begin
               w_col_n = r_col + DIM_W'(1);
               w_emit  = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase

      // One extra bit so off-screen sums are detected instead of wrapping.
      w_xs     = SX_W'(w_x0_n) + SX_W'(w_col_n);
      w_ys     = SY_W'(w_y0_n) + SY_W'(w_row_n);
      w_plot_n = w_emit && (w_xs < SX_W'(SCREEN_W)) && (w_ys < SY_W'(SCREEN_H));
   end

   // State, latches and registered outputs.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_state   <= ST_IDLE;
         r_win     <= '0;
         r_last    <= IDX_W'(NUM_REQ - 1);
         r_x0      <= '0;
         r_y0      <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_colour  <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_px      <= '0;
         r_py      <= '0;
         r_pcolour <= '0;
         r_plot    <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_win    <= w_win_n;
         r_last   <= w_last_n;
         r_x0     <= w_x0_n;
         r_y0     <= w_y0_n;
         r_w      <= w_w_n;
         r_h      <= w_h_n;
         r_colour <= w_colour_n;
         r_col    <= w_col_n;
         r_row    <= w_row_n;
         r_ack    <= w_ack_n;
         r_busy   <= (w_state_n != ST_IDLE);
         r_done   <= w_done_n;
         r_plot   <= w_plot_n;
         if (w_emit) begin
            r_px      <= w_xs[X_W-1:0];
            r_py      <= w_ys[Y_W-1:0];
            r_pcolour <= w_colour_n;
         end
      end
   end

   assign oAck    = r_ack;
   assign oBusy   = r_busy;
   assign oDone   = r_done;
   assign oX      = r_px;
   assign oY      = r_py;
   assign oColour = r_pcolour;
   assign oPlot   = r_plot;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: scenarios of rectangle requests
// are turned into an expected event timeline (grants, plotted pixels, done
// pulses) by a cycle-level reference model; a negedge monitor compares.
module tb_vga_draw_scheduler;
   import vga_pkg::*;

   localparam int NR = 4;
   localparam int DW = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic [NR-1:0]      req;
   logic [9*NR-1:0]    fx;
   logic [8*NR-1:0]    fy;
   logic [DW*NR-1:0]   fw;
   logic [DW*NR-1:0]   fh;
   logic [3*NR-1:0]    fc;
   logic [NR-1:0]      ack;
   logic               busy, done, plot;
   logic [8:0]         ox;
   logic [7:0]         oy;
   logic [2:0]         oc;

   vga_draw_scheduler #(.NUM_REQ(NR), .DIM_W(DW)) dut (
      .iClock  (clk),
      .iReset  (rst),
      .iReq    (req),
      .iX      (fx),
      .iY      (fy),
      .iW      (fw),
      .iH      (fh),
      .iColour (fc),
      .oAck    (ack),
      .oBusy   (busy),
      .oDone   (done),
      .oX      (ox),
      .oY      (oy),
      .oColour (oc),
      .oPlot   (plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 grant, 1 plotted pixel, 2 done
      int cyc;
      int a;
      int b;
      int c;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  n_total = 0;
   int  n_pass = 0;
   bit  mon_en = 1'b0;
   int  model_last;

   int s_cnt[NR], s_off[NR], s_x[NR], s_y[NR], s_w[NR], s_h[NR], s_col[NR];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic expect_ev(input int kind, input int a, input int b, input int c);
      ev_t e;
      if (q.size() == 0) begin
         chk("unexpected_output_kind", 1'b0, kind, -1);
      end else begin
         e = q.pop_front();
         n_total++;
         if (e.kind == kind && e.cyc == cyc && e.a == a && e.b == b && e.c == c)
            n_pass++;
         else
            $display("FAIL event: got kind=%0d cyc=%0d a=%0d b=%0d c=%0d expected kind=%0d cyc=%0d a=%0d b=%0d c=%0d",
                     kind, cyc, a, b, c, e.kind, e.cyc, e.a, e.b, e.c);
      end
   endtask

   // Monitor: every DUT output event must match the head of the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ack != '0) begin
            int idx;
            idx = -1;
            if ($countones(ack) == 1)
               for (int i = 0; i < NR; i++) if (ack[i]) idx = i;
            expect_ev(0, idx, 0, 0);
            chk("busy_at_grant", busy == 1'b1, int'(busy), 1);
         end
         if (plot) expect_ev(1, int'(ox), int'(oy), int'(oc));
         if (done) begin
            expect_ev(2, 0, 0, 0);
            chk("busy_at_done", busy == 1'b1, int'(busy), 1);
         end
      end
   end

   function automatic ev_t mk(input int k, input int t, input int a, input int b, input int c);
      ev_t e;
      e.kind = k; e.cyc = t; e.a = a; e.b = b; e.c = c;
      return e;
   endfunction

   task automatic clear_s();
      for (int i = 0; i < NR; i++) begin
         s_cnt[i] = 0; s_off[i] = 0; s_x[i] = 0; s_y[i] = 0;
         s_w[i] = 0; s_h[i] = 0; s_col[i] = 0;
      end
   endtask

   task automatic set_fields(input int i);
      fx[i*9 +: 9]   = 9'(s_x[i]);
      fy[i*8 +: 8]   = 8'(s_y[i]);
      fw[i*DW +: DW] = DW'(s_w[i]);
      fh[i*DW +: DW] = DW'(s_h[i]);
      fc[i*3 +: 3]   = 3'(s_col[i]);
   endtask

   task automatic scramble_fields(input int i);
      fx[i*9 +: 9]   = 9'($urandom);
      fy[i*8 +: 8]   = 8'($urandom);
      fw[i*DW +: DW] = DW'($urandom);
      fh[i*DW +: DW] = DW'($urandom);
      fc[i*3 +: 3]   = 3'($urandom);
   endtask

   // Called just after a negedge with the DUT idle. Requester i raises its
   // request at cycle c+s_off[i] and keeps it up until its s_cnt[i]-th grant.
   task automatic run_scenario();
      int c, t, best, mn, tend, pos, xs, ys;
      int rem[NR], acks[NR];
      bit raised[NR], dropped[NR], drop_nx[NR];
      bit any, fin;
      c   = cyc;
      rem = s_cnt;
      t   = c;
      // Reference timeline: IDLE at t, GRANT t+1, w*h pixels, DONE, IDLE.
      while (1) begin
         any = 1'b0;
         for (int i = 0; i < NR; i++) if (rem[i] > 0) any = 1'b1;
         if (!any) break;
         best = -1;
         for (int k = 1; k <= NR; k++) begin
            pos = (model_last + k) % NR;
            if (best < 0 && rem[pos] > 0 && c + s_off[pos] <= t) best = pos;
         end
         if (best < 0) begin
            mn = 1 << 30;
            for (int i = 0; i < NR; i++)
               if (rem[i] > 0 && c + s_off[i] < mn) mn = c + s_off[i];
            t = mn;
            continue;
         end
         q.push_back(mk(0, t + 1, best, 0, 0));
         for (int r = 0; r < s_h[best]; r++)
            for (int col = 0; col < s_w[best]; col++) begin
               xs = s_x[best] + col;
               ys = s_y[best] + r;
               if (xs < 320 && ys < 240)
                  q.push_back(mk(1, t + 2 + r * s_w[best] + col, xs, ys, s_col[best]));
            end
         q.push_back(mk(2, t + 2 + s_w[best] * s_h[best], 0, 0, 0));
         rem[best]--;
         model_last = best;
         t = t + 3 + s_w[best] * s_h[best];
      end
      tend = t;

      for (int i = 0; i < NR; i++) begin
         raised[i] = 1'b0; dropped[i] = 1'b0; drop_nx[i] = 1'b0; acks[i] = 0;
      end
      while (1) begin
         for (int i = 0; i < NR; i++) begin
            if (drop_nx[i]) begin
               req[i] = 1'b0;
               scramble_fields(i);
               drop_nx[i] = 1'b0;
               dropped[i] = 1'b1;
            end
            if (s_cnt[i] > 0 && !raised[i] && cyc >= c + s_off[i]) begin
               raised[i] = 1'b1;
               set_fields(i);
               req[i] = 1'b1;
            end
            if (ack[i] && raised[i] && !dropped[i]) begin
               acks[i]++;
               if (acks[i] == s_cnt[i]) drop_nx[i] = 1'b1;
            end
         end
         fin = (cyc > tend);
         for (int i = 0; i < NR; i++) if (s_cnt[i] > 0 && !dropped[i]) fin = 1'b0;
         if (fin) break;
         if (cyc > tend + 30) begin
            chk("scenario_timeout", 1'b0, cyc, tend);
            req = '0;
            break;
         end
         @(negedge clk);
      end
      chk("queue_drained", q.size() == 0, q.size(), 0);
      chk("idle_not_busy", busy == 1'b0, int'(busy), 0);
      q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack"},    ack == '0,  int'(ack),  0);
      chk({tag, "_busy"},   busy == 0,  int'(busy), 0);
      chk({tag, "_done"},   done == 0,  int'(done), 0);
      chk({tag, "_plot"},   plot == 0,  int'(plot), 0);
      chk({tag, "_x"},      ox == '0,   int'(ox),   0);
      chk({tag, "_y"},      oy == '0,   int'(oy),   0);
      chk({tag, "_colour"}, oc == '0,   int'(oc),   0);
   endtask

   initial begin
      int waited;
      rst = 1'b1; req = '0; fx = '0; fy = '0; fw = '0; fh = '0; fc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      model_last = NR - 1;
      mon_en = 1'b1;

      // Single request from client 0.
      clear_s();
      s_cnt[0] = 1; s_x[0] = 66; s_y[0] = 124; s_w[0] = 4; s_h[0] = 2; s_col[0] = int'(COL_YELLOW);
      run_scenario();

      // Clients 0 and 2 held for two grants each, 1x1 rectangles.
      clear_s();
      s_cnt[0] = 2; s_x[0] = 10; s_y[0] = 20; s_w[0] = 1; s_h[0] = 1; s_col[0] = int'(COL_WHITE);
      s_cnt[2] = 2; s_x[2] = 30; s_y[2] = 40; s_w[2] = 1; s_h[2] = 1; s_col[2] = 3;
      run_scenario();

      // Bottom-right clipping.
      clear_s();
      s_cnt[1] = 1; s_x[1] = 318; s_y[1] = 238; s_w[1] = 4; s_h[1] = 4; s_col[1] = 5;
      run_scenario();

      // Zero-width rectangle.
      clear_s();
      s_cnt[2] = 1; s_x[2] = 100; s_y[2] = 100; s_w[2] = 0; s_h[2] = 5; s_col[2] = 7;
      run_scenario();

      // Client 3 raised while client 1 is drawing.
      clear_s();
      s_cnt[1] = 1; s_x[1] = 5;  s_y[1] = 6;  s_w[1] = 4; s_h[1] = 4; s_col[1] = 2;
      s_cnt[3] = 1; s_x[3] = 50; s_y[3] = 60; s_w[3] = 2; s_h[3] = 1; s_col[3] = 4;
      s_off[3] = 5;
      run_scenario();

      // Reset in the middle of a 16x16 fill.
      mon_en = 1'b0;
      clear_s();
      s_x[0] = 10; s_y[0] = 10; s_w[0] = 16; s_h[0] = 16; s_col[0] = 1;
      set_fields(0);
      req[0] = 1'b1;
      waited = 0;
      while (ack[0] !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("abort_grant_seen", ack[0] == 1'b1, int'(ack[0]), 1);
      @(negedge clk);
      req[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_drawing", plot == 1'b1, int'(plot), 1);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      @(negedge clk);
      chk("midreset_no_done", done == 1'b0, int'(done), 0);
      q.delete();
      rst = 1'b0;
      model_last = NR - 1;
      mon_en = 1'b1;
      clear_s();
      s_cnt[0] = 1; s_x[0] = 1;  s_y[0] = 2; s_w[0] = 2; s_h[0] = 1; s_col[0] = 6;
      s_cnt[1] = 1; s_x[1] = 40; s_y[1] = 3; s_w[1] = 1; s_h[1] = 2; s_col[1] = 1;
      run_scenario();

      // Randomized scenarios.
      for (int n = 0; n < 25; n++) begin
         bit any;
         clear_s();
         any = 1'b0;
         for (int i = 0; i < NR; i++) begin
            s_cnt[i] = int'($urandom_range(0, 2));
            s_off[i] = int'($urandom_range(0, 6));
            s_x[i]   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(290, 335)) : int'($urandom_range(0, 300));
            s_y[i]   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(220, 250)) : int'($urandom_range(0, 220));
            s_w[i]   = int'($urandom_range(0, 5));
            s_h[i]   = int'($urandom_range(0, 5));
            s_col[i] = int'($urandom_range(0, 7));
            if (s_cnt[i] > 0) any = 1'b1;
         end
         if (!any) s_cnt[$urandom_range(0, NR - 1)] = 1;
         run_scenario();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_draw_scheduler.md
# vga_draw_scheduler

Arbitrates rectangle-fill requests from several display clients (note-key highlight, octave indicator, ADSR indicator, erase) and sequences the winner's rectangle onto the VGA adapter one pixel per clock. It sits between the per-feature display controllers and the VGA adapter's pixel port (`oX`/`oY`/`oColour`/`oPlot`). It replaces ad-hoc per-client plotting with one shared, round-robin-scheduled pixel writer.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..8.
- `DIM_W`, default 5: width of the rectangle size fields; max extent is 2^DIM_W − 1 pixels.
- `iClock`, in, 1: the single clock for the block.
- `iReset`, in, 1: reset, synchronous and active-high.
- `iReq`, in, NUM_REQ: per-requester request level.
- `iX`, in, 9*NUM_REQ: packed top-left x; requester i uses bits [9i+8:9i].
- `iY`, in, 8*NUM_REQ: packed top-left y.
- `iW`, in, DIM_W*NUM_REQ: packed width in pixels.
- `iH`, in, DIM_W*NUM_REQ: packed height in pixels.
- `iColour`, in, 3*NUM_REQ: packed 3-bit RGB colour.
- `oAck`, out, NUM_REQ: one-hot grant pulse, one cycle long.
- `oBusy`, out, 1: high whenever the state is not IDLE.
- `oDone`, out, 1: one-cycle pulse when a rectangle completes.
- `oX`, out, 9: pixel x to the VGA adapter.
- `oY`, out, 8: pixel y.
- `oColour`, out, 3: pixel colour.
- `oPlot`, out, 1: pixel write enable.

## Operation
- FSM states: IDLE, GRANT, DRAW, DONE.
- IDLE:
  - If any `iReq` bit is set, pick a winner by round-robin and go to GRANT.
  - Otherwise stay in IDLE.
- Round-robin rule:
  - The search starts at index `last+1` and wraps modulo NUM_REQ.
  - `last` updates to the winner index in GRANT.
  - On reset, `last` = NUM_REQ−1, so requester 0 has first priority.
- GRANT:
  - `oAck[winner]`=1.
  - Latch the winner's x, y, w, h and colour.
  - Clear the column and row counters to 0.
  - If w==0 or h==0, go to DONE. Otherwise go to DRAW.
- DRAW:
  - Each cycle, register one pixel: `oX`=x0+col, `oY`=y0+row, `oColour`=latched colour, and `oPlot`=1 unless clipped.
  - Scan order is raster: col increments first; when col==w−1, col returns to 0 and row increments.
  - After pixel (w−1, h−1), go to DONE.
- Clipping:
  - Compute x0+col in 10 bits and y0+row in 9 bits.
  - If x≥320 or y≥240, `oPlot`=0 for that cycle. The pixel slot is still consumed; there is no wrap-around onto the screen.
  - `oX`/`oY` carry the truncated low bits of the sum.
- DONE:
  - `oDone`=1 and `oPlot`=0.
  - Go to IDLE.
- Requester contract:
  - Hold `iReq` and all fields stable until `oAck` is seen.
  - Fields are sampled only in the GRANT cycle.
  - Deassert `iReq` on the cycle after `oAck` or later. A request still high in the next IDLE cycle is treated as a new request.
  - A requester that drops `iReq` before it is granted is simply not served.
- Requests arriving during GRANT, DRAW or DONE wait. They are evaluated only in IDLE.
- Reset values: all outputs 0, state IDLE, counters 0, `last`=NUM_REQ−1.
- Reset mid-DRAW aborts the rectangle. `oDone` does not fire for the aborted rectangle.

## Timing
- Registered outputs only; no combinational path from input to output.
- Request high in IDLE at cycle 0:
  - Cycle 1 is GRANT: `oAck` high.
  - Cycles 2 .. 1+w·h are DRAW: one pixel per cycle on the registered outputs.
  - Cycle 2+w·h is DONE: `oDone` high.
  - Cycle 3+w·h is IDLE, where the next request is sampled.
- Per-rectangle overhead is 3 cycles on top of w·h.
- Zero-size rectangle: GRANT at cycle 1, DONE at cycle 2, no `oPlot`.
- `oPlot` is 0 in IDLE, GRANT and DONE.

## Structure
- Shared package `vga_pkg` holds:
  - `SCREEN_W`=320, `SCREEN_H`=240, `COLOUR_W`=3.
  - The colour constants: black 3'b000, yellow 3'b110, white 3'b111.
  - The state encoding.
- Sub-module `rr_arbiter`:
  - Parameterized by NUM_REQ.
  - Inputs: request vector, `last` index.
  - Outputs: one-hot grant and encoded index, both combinational.
- The scheduler owns the FSM, the latches, the counters and the clip logic.

## Test plan
- Reset then single request:
  - Stimulus: req0 with x=66, y=124, w=4, h=2, colour=6.
  - Expect `oAck`=0001 at cycle 1.
  - Expect 8 plots: (66,124)…(69,124), then (66,125)…(69,125), all colour 6.
  - Expect `oDone` at cycle 10.
- Round-robin fairness:
  - Stimulus: req0 and req2 held continuously, each w=h=1.
  - Expect grant order 0, 2, 0, 2, with `oAck` spaced 4 cycles apart.
- Clipping:
  - Stimulus: x=318, y=238, w=4, h=4.
  - Expect `oPlot`=1 only for x∈{318,319} and y∈{238,239} (4 pixels).
  - Expect 16 DRAW cycles, with `oDone` at cycle 18.
- Zero-size rectangle:
  - Stimulus: w=0, h=5.
  - Expect GRANT then DONE, no `oPlot`, `oDone` at cycle 2.
- Reset mid-draw:
  - Stimulus: assert `iReset` during DRAW of a 16×16 rectangle.
  - Expect all outputs 0 in the next cycle and no `oDone`.
  - After release, a pending req1 and req0 grant req0 first.
- Late request:
  - Stimulus: req3 raised during DRAW of req1.
  - Expect req3 granted exactly 2 cycles after req1's `oDone` (one IDLE cycle, then GRANT).
